hv_step_start_seq: RTL and testbench
====================================

// Module: hv_step_start_seq
// PURPOSE
//  Downstream stage of the standby/HV interlock card; consumes its SB_on_b/SB_off_b, hv_on (OR/NAND) and
//  rf/hv_ready pass-throughs. Sequences the HV supply: main contactor with step-start resistor, timed
//  bypass, wait for anode HV ready, then RF enable. Latches faults until cleared with the request removed.
// PARAMETERS
//  STEP_CYCLES      1000  clk cycles main contactor is held with step-start resistor before bypass closes
//  READY_TIMEOUT    5000  max clk cycles in BYPASS waiting for i74_hv_ready before fault
//  PARTIAL_TIMEOUT  200   max consecutive clk cycles with only one of G2/anode on before fault
//  CNT_W            16    counter width; must hold max(STEP_CYCLES, READY_TIMEOUT, PARTIAL_TIMEOUT)
//  DEB_CYCLES       8     debounce length, used only with HV_SEQ_DEBOUNCE_EN
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  i47_SB_on_b    in   1  standby-on, active low (low = fan, G1, CA all on)
//  i42_SB_off_b   in   1  complement of i47_SB_on_b
//  i46_hv_on      in   1  OR(G2_on, anode_on)
//  i45_hv_on      in   1  NAND(G2_on, anode_on)
//  i78_rf_perm    in   1  rf_red permit
//  i76_rf_perm    in   1  rf permit
//  i74_hv_ready   in   1  anode HV ready
//  i_fault_clr    in   1  operator fault clear (level)
//  o_main_cont    out  1  main HV contactor drive
//  o_step_bypass  out  1  step-start resistor bypass contactor drive
//  o_hv_ready     out  1  HV sequence complete
//  o_rf_enable    out  1  RF drive enable
//  o_fault        out  1  latched fault
//  o_fault_code   out  2  0 none, 1 standby lost/absent, 2 G2/anode mismatch, 3 HV ready timeout/loss
//  o_state        out  3  IDLE=0, CONTACT=1, BYPASS=2, RUN=3, FAULT=4
// BEHAVIOUR
//  - Reset (async): state IDLE, counters 0, sync flops inactive (_b inputs 1, others 0); all outputs 0.
//  - Every i* input passes a 2-flop synchronizer; logic uses synced s* values only.
//  - Derived: sb_ok = ~s47 & s42; hv_req = s46 & ~s45 (both on); partial = s46 & s45 (exactly one on).
//  - Outputs are decoded from the state register only; fault_code is a register.
//  - Latency input edge -> state change: 3 clk (2 sync + 1 state).
//  - Partial counter: +1 each cycle partial=1, cleared when partial=0; count == PARTIAL_TIMEOUT-1 with
//    partial still 1 -> FAULT code 2, from any non-FAULT state.
//  - Priority each cycle: fault conditions > hv_req drop (to IDLE) > sequence progress.
//  - IDLE: all drives 0. hv_req & sb_ok -> CONTACT, seq cnt=0. hv_req & ~sb_ok -> FAULT code 1.
//  - CONTACT: o_main_cont=1. Counts; cnt == STEP_CYCLES-1 -> BYPASS, cnt=0. ~sb_ok -> FAULT code 1.
//  - BYPASS: main=1, bypass=1. s74 -> RUN. cnt == READY_TIMEOUT-1 without s74 -> FAULT code 3.
//  - RUN: main, bypass, o_hv_ready=1; o_rf_enable = s76 & s78 (combinational AND with synced permits).
//    s74 falls -> FAULT code 3; ~sb_ok -> FAULT code 1.
//  - hv_req drop (no fault) in CONTACT/BYPASS/RUN -> IDLE; drives 0 the next cycle.
//  - FAULT: all drives 0, o_fault=1, code held. Exit to IDLE only when s_fault_clr=1 & hv_req=0 &
//    partial=0; code cleared on exit. fault_clr with request still present: stay in FAULT.
//  - First fault wins: code not overwritten while in FAULT.
//  - Counters saturate; never wrap.
// CONFIGURATION
//  HV_SEQ_DEBOUNCE_EN defined: s46, s45, s47, s42 additionally pass a DEB_CYCLES-long stable-value filter
//  (output changes only after DEB_CYCLES consecutive equal synced samples); latency becomes 3+DEB_CYCLES.
//  Undefined: no filter, no DEB_CYCLES logic; latency 3 clk.
// TESTING (STEP_CYCLES=4, READY_TIMEOUT=8, PARTIAL_TIMEOUT=3, no debounce)
//  - Reset mid-RUN: assert reset -> all outputs 0 immediately, o_state=0 after release.
//  - Normal: SB_on_b=0, SB_off_b=1, hv_on46=1, hv_on45=0 -> CONTACT at +3 clk, BYPASS 4 clk later;
//    hv_ready=1 -> RUN, o_hv_ready=1; rf perms 1/1 -> o_rf_enable=1; perm 0 -> rf_enable 0, stays RUN.
//  - Ready timeout: stay in BYPASS with hv_ready=0 -> FAULT, code 3 after 8 cycles, drives 0.
//  - Mismatch: hv_on46=1, hv_on45=1 held -> FAULT code 2 after 3 synced cycles; short 2-cycle pulse -> no fault.
//  - Standby loss in RUN: SB_on_b=1 -> FAULT code 1; fault_clr with req high -> stays; req low + clr -> IDLE.
//  - Request drop in CONTACT -> IDLE, main contactor 0, o_fault=0.

Source files
------------

// File: rtl/hv_step_start_seq.sv
// rtl/hv_step_start_seq.sv - HV supply step-start sequencer with latched faults
//
// Sequences the HV supply downstream of the standby/HV interlock card:
// main contactor through the step-start resistor, timed resistor bypass,
// wait for anode HV ready, then RF enable. Any fault latches until the
// operator clears it with the HV request removed.
//
// Optional feature macro: HV_SEQ_DEBOUNCE_EN
//   defined   -> the standby and hv_on inputs also pass a DEB_CYCLES stable-value filter
//   undefined -> synchronizers only
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   i47_SB_on_b    in   standby on, active low
//   i42_SB_off_b   in   complement of i47_SB_on_b
//   i46_hv_on      in   OR(G2_on, anode_on)
//   i45_hv_on      in   NAND(G2_on, anode_on)
//   i78_rf_perm    in   rf_red permit
//   i76_rf_perm    in   rf permit
//   i74_hv_ready   in   anode HV ready
//   i_fault_clr    in   operator fault clear (level)
//   o_main_cont    out  main HV contactor drive
//   o_step_bypass  out  step-start resistor bypass contactor drive
//   o_hv_ready     out  HV sequence complete
//   o_rf_enable    out  RF drive enable
//   o_fault        out  latched fault
//   o_fault_code   out  0 none, 1 standby lost/absent, 2 G2/anode mismatch, 3 HV ready timeout/loss
//   o_state        out  IDLE=0, CONTACT=1, BYPASS=2, RUN=3, FAULT=4

module hv_step_start_seq #(
    parameter int STEP_CYCLES     = 1000,
    parameter int READY_TIMEOUT   = 5000,
    parameter int PARTIAL_TIMEOUT = 200,
    parameter int CNT_W           = 16
`ifdef HV_SEQ_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES      = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i47_SB_on_b,
    input  logic       i42_SB_off_b,
    input  logic       i46_hv_on,
    input  logic       i45_hv_on,
    input  logic       i78_rf_perm,
    input  logic       i76_rf_perm,
    input  logic       i74_hv_ready,
    input  logic       i_fault_clr,
    output logic       o_main_cont,
    output logic       o_step_bypass,
    output logic       o_hv_ready,
    output logic       o_rf_enable,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONTACT = 3'd1,
        ST_BYPASS  = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PART_LAST  = CNT_W'(PARTIAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Bit order {47, 42, 46, 45, 78, 76, 74, clr}; the two _b inputs idle high.
    localparam logic [7:0] SYNC_IDLE = 8'b1100_0000;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_SB      = 2'd1;
    localparam logic [1:0] CODE_PARTIAL = 2'd2;
    localparam logic [1:0] CODE_READY   = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [7:0] w_in;
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    assign w_in = {i47_SB_on_b, i42_SB_off_b, i46_hv_on, i45_hv_on,
                   i78_rf_perm, i76_rf_perm, i74_hv_ready, i_fault_clr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= SYNC_IDLE;
            r_sync2 <= SYNC_IDLE;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
        end
    end

    // Filtered view of {47, 42, 46, 45}
    logic [3:0] w_filt;

`ifdef HV_SEQ_DEBOUNCE_EN
    localparam int         DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [3:0] DEB_IDLE = 4'b1100;

    logic [3:0] r_deb_val;

    // A new level is accepted only after DEB_CYCLES consecutive synced
    // samples that differ from the current filtered value.
    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [DEB_W-1:0] r_deb_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_deb_cnt    <= '0;
                r_deb_val[g] <= DEB_IDLE[g];
            end else if (r_sync2[4+g] == r_deb_val[g]) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_deb_cnt    <= '0;
                r_deb_val[g] <= r_sync2[4+g];
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_filt = r_deb_val;
`else
    assign w_filt = r_sync2[7:4];
`endif

    logic w_s47, w_s42, w_s46, w_s45;
    logic w_s78, w_s76, w_s74, w_sclr;

    assign w_s47  = w_filt[3];
    assign w_s42  = w_filt[2];
    assign w_s46  = w_filt[1];
    assign w_s45  = w_filt[0];
    assign w_s78  = r_sync2[3];
    assign w_s76  = r_sync2[2];
    assign w_s74  = r_sync2[1];
    assign w_sclr = r_sync2[0];

    // Both supplies on: OR high and NAND low. Exactly one on: both high.
    logic w_sb_ok, w_hv_req, w_partial;

    assign w_sb_ok   = ~w_s47 & w_s42;
    assign w_hv_req  = w_s46 & ~w_s45;
    assign w_partial = w_s46 & w_s45;

    // ------------------------------------------------------------------
    // Partial (G2/anode mismatch) counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_part_cnt;
    logic             w_part_to;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_part_cnt <= '0;
        end else if (!w_partial) begin
            r_part_cnt <= '0;
        end else if (r_part_cnt != CNT_MAX) begin
            r_part_cnt <= r_part_cnt + 1'b1;
        end
    end

    assign w_part_to = w_partial && (r_part_cnt == PART_LAST);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_seq_cnt;
    logic [CNT_W-1:0] w_seq_cnt_nxt;
    logic [CNT_W-1:0] w_seq_inc;
    logic [1:0]       r_fault_code;
    logic [1:0]       w_code_nxt;

    assign w_seq_inc = (r_seq_cnt == CNT_MAX) ? r_seq_cnt : r_seq_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_seq_cnt    <= '0;
            r_fault_code <= CODE_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_seq_cnt    <= w_seq_cnt_nxt;
            r_fault_code <= w_code_nxt;
        end
    end

    // Per cycle: fault conditions first, then request drop, then progress.
    always_comb begin
        w_state_nxt   = r_state;
        w_seq_cnt_nxt = r_seq_cnt;
        w_code_nxt    = r_fault_code;

        if ((r_state != ST_FAULT) && w_part_to) begin
            w_state_nxt   = ST_FAULT;
            w_seq_cnt_nxt = '0;
            w_code_nxt    = CODE_PARTIAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hv_req && w_sb_ok) begin
                        w_state_nxt   = ST_CONTACT;
                        w_seq_cnt_nxt = '0;
                    end else if (w_hv_req) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = CODE_SB;
                    end
                end

                ST_CONTACT: begin
                    if (!w_sb_ok) begin
                        w_state_nxt   = ST_FAULT;
                        w_seq_cnt_nxt = '0;
                        w_code_nxt    = CODE_SB;
                    end else if (!w_hv_req) begin
                        w_state_nxt   = ST_IDLE;
                        w_seq_cnt_nxt = '0;
                    end else if (r_seq_cnt == STEP_LAST) begin
                        w_state_nxt   = ST_BYPASS;
                        w_seq_cnt_nxt = '0;
                    end else begin
                        w_seq_cnt_nxt = w_seq_inc;
                    end
                end

                ST_BYPASS: begin
                    // Standby loss is fatal in every energised state.
                    if (!w_sb_ok) begin
                        w_state_nxt   = ST_FAULT;
                        w_seq_cnt_nxt = '0;
                        w_code_nxt    = CODE_SB;
                    end else if (!w_s74 && (r_seq_cnt == READY_LAST)) begin
                        w_state_nxt   = ST_FAULT;
                        w_seq_cnt_nxt = '0;
                        w_code_nxt    = CODE_READY;
                    end else if (!w_hv_req) begin
                        w_state_nxt   = ST_IDLE;
                        w_seq_cnt_nxt = '0;
                    end else if (w_s74) begin
                        w_state_nxt   = ST_RUN;
                        w_seq_cnt_nxt = '0;
                    end else begin
                        w_seq_cnt_nxt = w_seq_inc;
                    end
                end

                ST_RUN: begin
                    if (!w_sb_ok) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = CODE_SB;
                    end else if (!w_s74) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = CODE_READY;
                    end else if (!w_hv_req) begin
                        w_state_nxt = ST_IDLE;
                    end
                end

                ST_FAULT: begin
                    // Code is held (first fault wins) until a clean clear.
                    if (w_sclr && !w_hv_req && !w_partial) begin
                        w_state_nxt   = ST_IDLE;
                        w_seq_cnt_nxt = '0;
                        w_code_nxt    = CODE_NONE;
                    end
                end

                default: begin
                    w_state_nxt   = ST_FAULT;
                    w_seq_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (state register only, plus synced permits for RF)
    // ------------------------------------------------------------------
    always_comb begin
        o_main_cont   = 1'b0;
        o_step_bypass = 1'b0;
        o_hv_ready    = 1'b0;
        o_rf_enable   = 1'b0;
        o_fault       = 1'b0;
        case (r_state)
            ST_CONTACT: begin
                o_main_cont = 1'b1;
            end
            ST_BYPASS: begin
                o_main_cont   = 1'b1;
                o_step_bypass = 1'b1;
            end
            ST_RUN: begin
                o_main_cont   = 1'b1;
                o_step_bypass = 1'b1;
                o_hv_ready    = 1'b1;
                o_rf_enable   = w_s76 & w_s78;
            end
            ST_FAULT: begin
                o_fault = 1'b1;
            end
            default: begin
                o_main_cont = 1'b0;
            end
        endcase
    end

    assign o_fault_code = r_fault_code;
    assign o_state      = r_state;

endmodule

// File: tb/tb_hv_step_start_seq.sv
// tb/tb_hv_step_start_seq.sv - self-checking bench for hv_step_start_seq
module tb_hv_step_start_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       i47_SB_on_b, i42_SB_off_b, i46_hv_on, i45_hv_on;
    logic       i78_rf_perm, i76_rf_perm, i74_hv_ready, i_fault_clr;
    logic       o_main_cont, o_step_bypass, o_hv_ready, o_rf_enable, o_fault;
    logic [1:0] o_fault_code;
    logic [2:0] o_state;

    hv_step_start_seq #(
        .STEP_CYCLES    (4),
        .READY_TIMEOUT  (8),
        .PARTIAL_TIMEOUT(3),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i47_SB_on_b  (i47_SB_on_b),
        .i42_SB_off_b (i42_SB_off_b),
        .i46_hv_on    (i46_hv_on),
        .i45_hv_on    (i45_hv_on),
        .i78_rf_perm  (i78_rf_perm),
        .i76_rf_perm  (i76_rf_perm),
        .i74_hv_ready (i74_hv_ready),
        .i_fault_clr  (i_fault_clr),
        .o_main_cont  (o_main_cont),
        .o_step_bypass(o_step_bypass),
        .o_hv_ready   (o_hv_ready),
        .o_rf_enable  (o_rf_enable),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    // Stimulus byte: {SB_on_b, SB_off_b, hv46, hv45, rf78, rf76, hv_ready74, fault_clr}
    localparam logic [7:0] S_OFF      = 8'h90; // standby off, HV off
    localparam logic [7:0] S_SB       = 8'h50; // standby on, HV off
    localparam logic [7:0] S_SB_CLR   = 8'h51;
    localparam logic [7:0] S_REQ      = 8'h60; // standby on, G2+anode on
    localparam logic [7:0] S_REQ_RDY  = 8'h62;
    localparam logic [7:0] S_REQ_RF   = 8'h6E;
    localparam logic [7:0] S_REQ_RF1  = 8'h6A; // only rf_red permit
    localparam logic [7:0] S_PART     = 8'h70; // standby on, one of G2/anode
    localparam logic [7:0] S_ABSENT   = 8'hA0; // HV request, no standby
    localparam logic [7:0] S_LOST     = 8'hA2;
    localparam logic [7:0] S_LOST_CLR = 8'hA3;
    localparam logic [7:0] S_PART_CLR = 8'hB3; // standby lost, mismatch, clear
    localparam logic [7:0] S_OFF_CLR  = 8'h91;

    localparam logic [2:0] IDLE = 3'd0, CONTACT = 3'd1, BYPASS = 3'd2, RUN = 3'd3, FAULT = 3'd4;

    typedef struct {
        string      name;
        logic [7:0] stim;
        int         wait_n;
        logic [2:0] st;
        logic [1:0] code;
        logic       rf;
    } step_t;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic step_t mk(string n, logic [7:0] s, int w, logic [2:0] st, logic [1:0] c, logic rf);
        step_t t;
        t.name = n; t.stim = s; t.wait_n = w; t.st = st; t.code = c; t.rf = rf;
        return t;
    endfunction

    // Expected {state, code, main, bypass, hv_ready, rf_enable, fault}
    function automatic logic [9:0] expv(logic [2:0] st, logic [1:0] code, logic rf);
        logic m, b, r, f;
        m = (st == CONTACT) || (st == BYPASS) || (st == RUN);
        b = (st == BYPASS) || (st == RUN);
        r = (st == RUN);
        f = (st == FAULT);
        return {st, code, m, b, r, r & rf, f};
    endfunction

    function automatic logic [9:0] obs();
        return {o_state, o_fault_code, o_main_cont, o_step_bypass, o_hv_ready, o_rf_enable, o_fault};
    endfunction

    task automatic apply(logic [7:0] s);
        {i47_SB_on_b, i42_SB_off_b, i46_hv_on, i45_hv_on,
         i78_rf_perm, i76_rf_perm, i74_hv_ready, i_fault_clr} = s;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        apply(S_OFF);
        sb_q.push_back('{"reset_hold", expv(IDLE, 2'd0, 1'b0)});
        repeat (2) @(negedge clk);
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
        end
        reset = 1'b0;
        sb_q.push_back('{"reset_release", expv(IDLE, 2'd0, 1'b0)});
        repeat (3) @(negedge clk);
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    task automatic test_normal();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk("norm_pre",         S_REQ,     2, IDLE,    2'd0, 1'b0));
        steps.push_back(mk("norm_contact",     S_REQ,     1, CONTACT, 2'd0, 1'b0));
        steps.push_back(mk("norm_contact_hold",S_REQ,     3, CONTACT, 2'd0, 1'b0));
        steps.push_back(mk("norm_bypass",      S_REQ,     1, BYPASS,  2'd0, 1'b0));
        steps.push_back(mk("norm_run",         S_REQ_RDY, 3, RUN,     2'd0, 1'b0));
        steps.push_back(mk("norm_rf_on",       S_REQ_RF,  3, RUN,     2'd0, 1'b1));
        steps.push_back(mk("norm_rf_perm_off", S_REQ_RF1, 3, RUN,     2'd0, 1'b0));
        foreach (steps[k]) begin
            apply(steps[k].stim);
            sb_q.push_back('{steps[k].name, expv(steps[k].st, steps[k].code, steps[k].rf)});
            repeat (steps[k].wait_n) @(negedge clk);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        apply(S_REQ_RF);
        sb_q.push_back('{"rst_pre_run", expv(RUN, 2'd0, 1'b1)});
        repeat (3) @(negedge clk);
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
        end
        #2;
        reset = 1'b1;
        sb_q.push_back('{"rst_async_outputs", 10'd0});
        #1;
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
        end
        apply(S_OFF);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.push_back('{"rst_after_release", expv(IDLE, 2'd0, 1'b0)});
        @(negedge clk);
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    task automatic test_ready_timeout();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk("to_contact", S_REQ,     3, CONTACT, 2'd0, 1'b0));
        steps.push_back(mk("to_bypass",  S_REQ,     4, BYPASS,  2'd0, 1'b0));
        steps.push_back(mk("to_wait",    S_REQ,     7, BYPASS,  2'd0, 1'b0));
        steps.push_back(mk("to_fault",   S_REQ,     1, FAULT,   2'd3, 1'b0));
        steps.push_back(mk("to_clr",     S_OFF_CLR, 3, IDLE,    2'd0, 1'b0));
        steps.push_back(mk("to_idle",    S_OFF,     2, IDLE,    2'd0, 1'b0));
        foreach (steps[k]) begin
            apply(steps[k].stim);
            sb_q.push_back('{steps[k].name, expv(steps[k].st, steps[k].code, steps[k].rf)});
            repeat (steps[k].wait_n) @(negedge clk);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_mismatch();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk("mm_pulse",      S_PART,   2, IDLE,  2'd0, 1'b0));
        steps.push_back(mk("mm_pulse_gone", S_SB,     5, IDLE,  2'd0, 1'b0));
        steps.push_back(mk("mm_hold",       S_PART,   4, IDLE,  2'd0, 1'b0));
        steps.push_back(mk("mm_fault",      S_PART,   1, FAULT, 2'd2, 1'b0));
        steps.push_back(mk("mm_clr",        S_SB_CLR, 3, IDLE,  2'd0, 1'b0));
        steps.push_back(mk("mm_idle",       S_SB,     2, IDLE,  2'd0, 1'b0));
        foreach (steps[k]) begin
            apply(steps[k].stim);
            sb_q.push_back('{steps[k].name, expv(steps[k].st, steps[k].code, steps[k].rf)});
            repeat (steps[k].wait_n) @(negedge clk);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_standby_loss();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk("sb_contact",     S_REQ_RDY,  3, CONTACT, 2'd0, 1'b0));
        steps.push_back(mk("sb_bypass",      S_REQ_RDY,  4, BYPASS,  2'd0, 1'b0));
        steps.push_back(mk("sb_run",         S_REQ_RDY,  1, RUN,     2'd0, 1'b0));
        steps.push_back(mk("sb_lost",        S_LOST,     3, FAULT,   2'd1, 1'b0));
        steps.push_back(mk("sb_clr_req",     S_LOST_CLR, 5, FAULT,   2'd1, 1'b0));
        steps.push_back(mk("sb_first_wins",  S_PART_CLR, 5, FAULT,   2'd1, 1'b0));
        steps.push_back(mk("sb_exit",        S_OFF_CLR,  3, IDLE,    2'd0, 1'b0));
        steps.push_back(mk("sb_idle",        S_OFF,      2, IDLE,    2'd0, 1'b0));
        steps.push_back(mk("sb_absent",      S_ABSENT,   3, FAULT,   2'd1, 1'b0));
        steps.push_back(mk("sb_absent_exit", S_OFF_CLR,  3, IDLE,    2'd0, 1'b0));
        steps.push_back(mk("sb_absent_idle", S_OFF,      2, IDLE,    2'd0, 1'b0));
        foreach (steps[k]) begin
            apply(steps[k].stim);
            sb_q.push_back('{steps[k].name, expv(steps[k].st, steps[k].code, steps[k].rf)});
            repeat (steps[k].wait_n) @(negedge clk);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_req_drop();
        step_t steps[$];
        exp_t  e;
        steps.push_back(mk("rd_contact", S_REQ, 3, CONTACT, 2'd0, 1'b0));
        steps.push_back(mk("rd_hold",    S_SB,  2, CONTACT, 2'd0, 1'b0));
        steps.push_back(mk("rd_idle",    S_SB,  1, IDLE,    2'd0, 1'b0));
        foreach (steps[k]) begin
            apply(steps[k].stim);
            sb_q.push_back('{steps[k].name, expv(steps[k].st, steps[k].code, steps[k].rf)});
            repeat (steps[k].wait_n) @(negedge clk);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_reset_mid_run();
        test_ready_timeout();
        test_mismatch();
        test_standby_loss();
        test_req_drop();
        n_run++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
